sseg_scan_controller: RTL and testbench

- Parametrised multiplexed seven-segment scan controller for the board's common-anode display bank.
- Contains its own tick prescaler, digit scan counter, hex decoder, per-digit blank and DP masks, and PWM brightness control.
- Takes a frame-synchronous snapshot of the digit data so the display never tears mid-frame.
- Sits between game/display logic and the top-level sseg, DP and AN pins, replacing the fixed 8-digit timer+counter+driver arrangement.

---
 rtl/sseg_scan_controller.sv | 194 +++++++++++++++++++
 tb/tb_sseg_scan_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_controller.sv
// Multiplexed seven-segment scan controller for a common-anode display bank.
// Holds its own slot prescaler, PWM sub-slot counter and digit scan counter.
// Digit data is staged on load and committed only at a frame boundary, so a
// frame is always drawn from one consistent snapshot.
module sseg_scan_controller #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned SLOT_TICKS  = 5208,
    parameter int unsigned BRIGHT_BITS = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [6:0]              sseg,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int unsigned TW = $clog2(SLOT_TICKS);
    localparam int unsigned DW = $clog2(NUM_DIGITS);

    // Scan counters
    logic [TW-1:0]          tick_q, tick_d;
    logic [BRIGHT_BITS-1:0] sub_q, sub_d;
    logic [DW-1:0]          dig_q, dig_d;
    logic                   tick_last, sub_last, dig_last;

    // Staging (written by load) and display (committed at frame end) registers
    logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d;
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

    // Currently scanned digit and registered pin drivers
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank, lit;
    logic [6:0]            seg_dec;
    logic [6:0]            sseg_q, sseg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    assign tick_last  = (tick_q == TW'(SLOT_TICKS - 1));
    assign sub_last   = (sub_q == '1);
    assign dig_last   = (dig_q == DW'(NUM_DIGITS - 1));
    // Asserted in the cycle whose closing edge wraps the digit counter to 0
    assign frame_done = enable & tick_last & sub_last & dig_last;
    assign pending    = pend_q;
    assign sseg       = sseg_q;
    assign DP         = dp_q;
    assign an         = an_q;

    // Next-state for the prescaler, sub-slot and digit counters; all hold when disabled
    always_comb begin
        tick_d = tick_q;
        sub_d  = sub_q;
        dig_d  = dig_q;
        if (enable) begin
            if (tick_last) begin
                tick_d = '0;
                sub_d  = sub_q + BRIGHT_BITS'(1);
                if (sub_last) begin
                    dig_d = dig_last ? '0 : dig_q + DW'(1);
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    // Snapshot staging and frame-boundary commit
    always_comb begin
        stg_val_d    = stg_val_q;
        stg_dp_d     = stg_dp_q;
        stg_blank_d  = stg_blank_q;
        pend_d       = pend_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        if (frame_done) begin
            // A load coinciding with the boundary bypasses staging entirely
            if (load) begin
                disp_val_d   = digits_in;
                disp_dp_d    = dp_in;
                disp_blank_d = blank_in;
            end else if (pend_q) begin
                disp_val_d   = stg_val_q;
                disp_dp_d    = stg_dp_q;
                disp_blank_d = stg_blank_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            stg_val_d   = digits_in;
            stg_dp_d    = dp_in;
            stg_blank_d = blank_in;
            pend_d      = 1'b1;
        end
    end

    // Select the display data for the digit currently being scanned
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (dig_q == DW'(i)) begin
                cur_nib   = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = disp_blank_q[i];
            end
        end
    end

    // Hex to active-low {a,b,c,d,e,f,g}
    always_comb begin
        seg_dec = 7'h7F;
        unique case (cur_nib)
            4'h0:    seg_dec = 7'b0000001;
            4'h1:    seg_dec = 7'b1001111;
            4'h2:    seg_dec = 7'b0010010;
            4'h3:    seg_dec = 7'b0000110;
            4'h4:    seg_dec = 7'b1001100;
            4'h5:    seg_dec = 7'b0100100;
            4'h6:    seg_dec = 7'b0100000;
            4'h7:    seg_dec = 7'b0001111;
            4'h8:    seg_dec = 7'b0000000;
            4'h9:    seg_dec = 7'b0000100;
            4'hA:    seg_dec = 7'b0001000;
            4'hB:    seg_dec = 7'b1100000;
            4'hC:    seg_dec = 7'b0110001;
            4'hD:    seg_dec = 7'b1000010;
            4'hE:    seg_dec = 7'b0110000;
            4'hF:    seg_dec = 7'b0111000;
            default: seg_dec = 7'h7F;
        endcase
    end

    // Pin values for the current counter state; PWM lights sub-slots 0..brightness
    always_comb begin
        lit    = enable && (sub_q <= brightness) && !cur_blank;
        sseg_d = 7'h7F;
        dp_d   = 1'b1;
        an_d   = '1;
        if (lit) begin
            sseg_d = seg_dec;
            dp_d   = ~cur_dp;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (dig_q != DW'(i));
            end
        end
    end

    // State registers; segments, DP and anodes update together on one edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q       <= '0;
            sub_q        <= '0;
            dig_q        <= '0;
            stg_val_q    <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '0;
            pend_q       <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
            sseg_q       <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
        end else begin
            tick_q       <= tick_d;
            sub_q        <= sub_d;
            dig_q        <= dig_d;
            stg_val_q    <= stg_val_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            pend_q       <= pend_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            sseg_q       <= sseg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with 4 digits, 4 ticks per sub-slot
// and 2 brightness bits: 16 clocks per digit, 64 clocks per frame.
module tb_sseg_scan_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [1:0]  brightness;
    logic [6:0]  sseg;
    logic        DP;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [1:0]      bright;
        logic [3:0][6:0] seg;  // expected segments, index = digit
        logic [3:0][4:0] cnt;  // expected anode-low clocks per digit in one frame
    } vec_t;

    vec_t vecs[7];

    sseg_scan_controller #(
        .NUM_DIGITS (4),
        .SLOT_TICKS (4),
        .BRIGHT_BITS(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .load      (load),
        .brightness(brightness),
        .sseg      (sseg),
        .DP        (DP),
        .an        (an),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_fd;
        int n = 0;
        while (!frame_done && n < 100) begin
            tick();
            n++;
        end
        chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    // Entered just after the commit edge (counter state 0); checks one full frame
    task automatic check_frame(input vec_t v, input string tag);
        int         lit_cnt[4];
        int         d, s;
        logic       lit;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
        for (int p = 0; p < 64; p++) begin
            tick();
            d       = p / 16;
            s       = (p % 16) / 4;
            lit     = (s <= int'(v.bright)) && !v.blank[d];
            exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
            exp_seg = lit ? v.seg[d] : 7'h7F;
            exp_dp  = lit ? ~v.dp[d] : 1'b1;
            chk($sformatf("%s_pins_p%0d", tag, p), {20'd0, an, sseg, DP},
                {20'd0, exp_an, exp_seg, exp_dp});
            if (an[d] == 1'b0) lit_cnt[d]++;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_lit_count_d%0d", tag, k), lit_cnt[k], {27'd0, v.cnt[k]});
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        digits_in  = v.digits;
        dp_in      = v.dp;
        blank_in   = v.blank;
        brightness = v.bright;
        load       = 1'b1;
        tick();
        load = 1'b0;
        chk({tag, "_pending_set"}, {31'd0, pending}, 32'd1);
        wait_fd();
        chk({tag, "_pending_at_fd"}, {31'd0, pending}, 32'd1);
        tick();
        chk({tag, "_pending_clr"}, {31'd0, pending}, 32'd0);
        check_frame(v, tag);
    endtask

    initial begin
        vecs[0].digits = 16'h8A01; vecs[0].dp = 4'b0100; vecs[0].blank = 4'b0000;
        vecs[0].bright = 2'd3;
        vecs[0].seg = {7'b0000000, 7'b0001000, 7'b0000001, 7'b1001111};
        vecs[0].cnt = {5'd16, 5'd16, 5'd16, 5'd16};

        vecs[1] = vecs[0];
        vecs[1].bright = 2'd0;
        vecs[1].cnt = {5'd4, 5'd4, 5'd4, 5'd4};

        vecs[2] = vecs[0];
        vecs[2].blank = 4'b0010;
        vecs[2].cnt = {5'd16, 5'd16, 5'd0, 5'd16};

        vecs[3].digits = 16'h5C3E; vecs[3].dp = 4'b1001; vecs[3].blank = 4'b0000;
        vecs[3].bright = 2'd1;
        vecs[3].seg = {7'b0100100, 7'b0110001, 7'b0000110, 7'b0110000};
        vecs[3].cnt = {5'd8, 5'd8, 5'd8, 5'd8};

        vecs[4].digits = 16'hBD97; vecs[4].dp = 4'b0000; vecs[4].blank = 4'b1000;
        vecs[4].bright = 2'd2;
        vecs[4].seg = {7'b1100000, 7'b1000010, 7'b0000100, 7'b0001111};
        vecs[4].cnt = {5'd0, 5'd12, 5'd12, 5'd12};

        vecs[5].digits = 16'h6420; vecs[5].dp = 4'b0010; vecs[5].blank = 4'b0000;
        vecs[5].bright = 2'd3;
        vecs[5].seg = {7'b0100000, 7'b1001100, 7'b0010010, 7'b0000001};
        vecs[5].cnt = {5'd16, 5'd16, 5'd16, 5'd16};

        vecs[6].digits = 16'hFFFF; vecs[6].dp = 4'b0000; vecs[6].blank = 4'b0000;
        vecs[6].bright = 2'd3;
        vecs[6].seg = {7'b0111000, 7'b0111000, 7'b0111000, 7'b0111000};
        vecs[6].cnt = {5'd16, 5'd16, 5'd16, 5'd16};

        // Reset state, with a load request that must be ignored
        reset_n    = 1'b0;
        enable     = 1'b1;
        digits_in  = 16'h1234;
        dp_in      = 4'hF;
        blank_in   = 4'h0;
        load       = 1'b1;
        brightness = 2'd3;
        repeat (3) tick();
        load = 1'b0;
        chk("rst_sseg", {25'd0, sseg}, 32'h7F);
        chk("rst_dp", {31'd0, DP}, 32'd1);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_pending", {31'd0, pending}, 32'd0);

        // Dark display after reset; frame_done every 64 clocks
        reset_n = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            chk($sformatf("idle_an_%0d", i), {28'd0, an}, 32'hF);
            chk($sformatf("idle_fd_%0d", i), {31'd0, frame_done},
                {31'd0, (i % 64) == 63});
        end
        chk("idle_pending", {31'd0, pending}, 32'd0);

        // Counter state is now 8; load lands at state 10
        repeat (2) tick();
        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
        end

        // Load coinciding with frame_done commits directly
        digits_in  = vecs[6].digits;
        dp_in      = vecs[6].dp;
        blank_in   = vecs[6].blank;
        brightness = vecs[6].bright;
        wait_fd();
        chk("direct_pending_before", {31'd0, pending}, 32'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("direct_pending_after", {31'd0, pending}, 32'd0);
        check_frame(vecs[6], "direct");

        // Hold for 20 clocks mid-digit (state 5), loading during the hold
        repeat (5) tick();
        enable    = 1'b0;
        digits_in = 16'h1234;
        dp_in     = 4'h0;
        blank_in  = 4'h0;
        load      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            load = 1'b0;
            chk($sformatf("hold_an_%0d", i), {28'd0, an}, 32'hF);
            chk($sformatf("hold_fd_%0d", i), {31'd0, frame_done}, 32'd0);
        end
        chk("hold_pending", {31'd0, pending}, 32'd1);
        enable = 1'b1;
        tick();
        // Resumes at held state 5: digit 0, sub-slot 1, showing F
        chk("resume_pins", {21'd0, an, sseg}, {21'd0, 4'b1110, 7'b0111000});
        for (int k = 1; k <= 57; k++) begin
            tick();
            chk($sformatf("resume_fd_%0d", k), {31'd0, frame_done}, {31'd0, k == 57});
        end
        tick();
        chk("resume_commit", {31'd0, pending}, 32'd0);

        // Stage another value, then reset mid-frame while it is pending
        digits_in = 16'h4321;
        load      = 1'b1;
        tick();
        load = 1'b0;
        repeat (10) tick();
        // State 10 was drawn: digit 0 of 16'h1234 is 4
        chk("prerst_pins", {21'd0, an, sseg}, {21'd0, 4'b1110, 7'b1001100});
        chk("prerst_pending", {31'd0, pending}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_sseg", {25'd0, sseg}, 32'h7F);
        chk("async_dp", {31'd0, DP}, 32'd1);
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_frame_done", {31'd0, frame_done}, 32'd0);
        chk("async_pending", {31'd0, pending}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            chk($sformatf("postrst_an_%0d", i), {28'd0, an}, 32'hF);
            chk($sformatf("postrst_pend_%0d", i), {31'd0, pending}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
